// File: rtl/pong_uart_pkg.sv
// Shared types and constants for the paddle UART receiver.
// Holds the RX state enum, command bytes and default clock/baud values.
package pong_uart_pkg;

  localparam int DEF_CLK_FREQ = 50000000;
  localparam int DEF_BAUD     = 115200;

  localparam logic [7:0] CMD_P1_UP    = 8'h77;
  localparam logic [7:0] CMD_P1_DN    = 8'h73;
  localparam logic [7:0] CMD_P2_UP    = 8'h69;
  localparam logic [7:0] CMD_P2_DN    = 8'h6B;
  localparam logic [7:0] CMD_START_SP = 8'h20;
  localparam logic [7:0] CMD_START_CR = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: 2-flop synchroniser, bit timer and RX FSM.
// Ports: clk, rst (async high), i_rx serial in; o_byte_valid/o_data/o_frame_err.
// Config: UART_PARITY_EN selects 8E1 framing, otherwise 8N1.
module uart_rx_core
  import pong_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_data,
  output logic       o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic            r_s1;
  logic            r_s2;
  logic            r_s3;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            w_tick;
  logic            w_fall;

  assign w_tick = (r_cnt == FULL);
  // r_s3 is only a delayed copy used for edge detection
  assign w_fall = r_s3 & ~r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_s3    <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_s1    <= i_rx;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            // still high at mid start bit: treat as a glitch
            r_state <= r_s2 ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_data <= {r_s2, r_data[7:1]};
            r_idx  <= r_idx + 1'b1;
            if (r_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_s2 != ^r_data) begin
              r_ferr  <= 1'b1;
              r_state <= ST_WAIT_IDLE;
            end else begin
              r_state <= ST_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_s2) begin
              r_valid <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (r_s2) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_byte_valid = r_valid;
  assign o_data       = r_data;
  assign o_frame_err  = r_ferr;

endmodule

// File: rtl/uart_paddle_rx.sv
// Paddle command front end: decodes UART bytes into held directions + start pulse.
// Ports: clk, rst, uart_rx in; p1/p2 up/down, start_trigger, frame_err out.
// Config: UART_PARITY_EN (passed to uart_rx_core) selects 8E1 framing.
module uart_paddle_rx
  import pong_uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD,
  parameter int HOLD_MS  = 150
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  output logic p1_up,
  output logic p1_down,
  output logic p2_up,
  output logic p2_down,
  output logic start_trigger,
  output logic frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HOLD_CYCLES  = CLK_FREQ / 1000 * HOLD_MS;
  localparam int TW           = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_V = TW'(HOLD_CYCLES);

  logic          w_byte_valid;
  logic [7:0]    w_data;
  logic          w_p1u;
  logic          w_p1d;
  logic          w_p2u;
  logic          w_p2d;
  logic          w_start;
  logic [TW-1:0] r_t_p1u;
  logic [TW-1:0] r_t_p1d;
  logic [TW-1:0] r_t_p2u;
  logic [TW-1:0] r_t_p2d;
  logic          r_start;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (uart_rx),
    .o_byte_valid(w_byte_valid),
    .o_data      (w_data),
    .o_frame_err (frame_err)
  );

  assign w_p1u   = w_byte_valid && (w_data == CMD_P1_UP);
  assign w_p1d   = w_byte_valid && (w_data == CMD_P1_DN);
  assign w_p2u   = w_byte_valid && (w_data == CMD_P2_UP);
  assign w_p2d   = w_byte_valid && (w_data == CMD_P2_DN);
  assign w_start = w_byte_valid &&
                   (w_data == CMD_START_SP ||
                    w_data == CMD_START_CR);

  // reload beats expiry; the opposite command clears
  function automatic logic [TW-1:0] nxt(
    input logic [TW-1:0] t,
    input logic          ld,
    input logic          clr
  );
    if (ld)           return HOLD_V;
    else if (clr)     return '0;
    else if (t != '0) return t - 1'b1;
    else              return t;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t_p1u <= '0;
      r_t_p1d <= '0;
      r_t_p2u <= '0;
      r_t_p2d <= '0;
      r_start <= 1'b0;
    end else begin
      r_t_p1u <= nxt(r_t_p1u, w_p1u, w_p1d);
      r_t_p1d <= nxt(r_t_p1d, w_p1d, w_p1u);
      r_t_p2u <= nxt(r_t_p2u, w_p2u, w_p2d);
      r_t_p2d <= nxt(r_t_p2d, w_p2d, w_p2u);
      r_start <= w_start;
    end
  end

  assign p1_up         = (r_t_p1u != '0);
  assign p1_down       = (r_t_p1d != '0);
  assign p2_up         = (r_t_p2u != '0);
  assign p2_down       = (r_t_p2d != '0);
  assign start_trigger = r_start;

endmodule

// File: tb/tb_uart_paddle_rx.sv
// Directed bench for uart_paddle_rx at a scaled clock.
// 20 clks per bit, 1000-cycle hold time.
module tb_uart_paddle_rx;

  localparam int CPB  = 20;
  localparam int HOLD = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic p1_up, p1_down, p2_up, p2_down;
  logic start_trigger, frame_err;

  int n_chk = 0;
  int n_err = 0;

  int cyc = 0;
  int nvalid = 0;
  int nferr = 0;
  int nstart = 0;
  int nrise = 0;
  int last_p1 = 0;
  int last_p2 = 0;
  int fall_p1 = 0;
  int fall_p2 = 0;
  int low_p1 = 0;
  int low_p2 = 0;
  bit mon = 0;
  logic pv_p1 = 0;
  logic pv_p2 = 0;
  logic pv_st = 0;

  uart_paddle_rx #(
    .CLK_FREQ(100000),
    .BAUD    (5000),
    .HOLD_MS (10)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .p1_up        (p1_up),
    .p1_down      (p1_down),
    .p2_up        (p2_up),
    .p2_down      (p2_down),
    .start_trigger(start_trigger),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (u_dut.w_byte_valid) begin
        nvalid++;
        if (u_dut.w_data == 8'h77) last_p1 = cyc;
        if (u_dut.w_data == 8'h69) last_p2 = cyc;
      end
      if (pv_p1 && !p1_up) fall_p1 = cyc;
      if (pv_p2 && !p2_up) fall_p2 = cyc;
      if (mon && !p1_up) low_p1++;
      if (mon && !p2_up) low_p2++;
      if (start_trigger) nstart++;
      if (start_trigger && !pv_st) nrise++;
      if (frame_err) nferr++;
      pv_p1 = p1_up;
      pv_p2 = p2_up;
      pv_st = start_trigger;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // leaves the stop level on the line; caller idles afterwards
  task automatic send_byte(input logic [7:0] d, input logic stop,
                           input logic bad_par);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      idle(CPB);
    end
`ifdef UART_PARITY_EN
    uart_rx = (^d) ^ bad_par;
    idle(CPB);
`else
    if (bad_par) uart_rx = 1'b1;
`endif
    uart_rx = stop;
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (u_dut.w_byte_valid) begin
        ok = 1;
        break;
      end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  function automatic logic [31:0] outs();
    return {26'd0, p1_up, p1_down, p2_up, p2_down,
            start_trigger, frame_err};
  endfunction

  initial begin
    int cnt;
    int nv0;
    int nf0;
    bit seen_dn;

    idle(3);
    chk("reset_outs", outs(), 32'd0);
    chk("reset_sync", {31'd0, u_dut.u_core.r_s2}, 32'd1);
    rst = 1'b0;
    idle(10);

    // reset in the middle of a frame while p1_down is held
    send_byte(8'h73, 1'b1, 1'b0);
    wait_valid("v_73a");
    idle(2);
    chk("p1dn_set", {31'd0, p1_down}, 32'd1);
    idle(CPB);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx = i[0] ? 1'b1 : 1'b1 ^ 1'b0;
      idle(CPB);
    end
    rst = 1'b1;
    #1;
    chk("rst_mid", outs(), 32'd0);
    uart_rx = 1'b1;
    idle(5);
    rst = 1'b0;
    idle(40);

    // latency and exact hold length
    send_byte(8'h77, 1'b1, 1'b0);
    wait_valid("v_77a");
    chk("lat_pre", {31'd0, p1_up}, 32'd0);
    @(negedge clk);
    chk("lat_post", {31'd0, p1_up}, 32'd1);
    cnt = 1;
    seen_dn = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (p1_down) seen_dn = 1;
      if (!p1_up) break;
      cnt++;
    end
    chk("hold_len", cnt, HOLD);
    chk("hold_no_dn", {31'd0, seen_dn}, 32'd0);

    // opposite command swaps on the same clock
    send_byte(8'h77, 1'b1, 1'b0);
    idle(300);
    send_byte(8'h73, 1'b1, 1'b0);
    wait_valid("v_73b");
    chk("swap_pre", {30'd0, p1_up, p1_down}, 32'd2);
    @(negedge clk);
    chk("swap_post", {30'd0, p1_up, p1_down}, 32'd1);
    idle(HOLD + 100);
    chk("swap_expire", outs(), 32'd0);

    // both players with autorepeat
    for (int r = 0; r < 6; r++) begin
      send_byte(8'h69, 1'b1, 1'b0);
      idle(CPB);
      send_byte(8'h77, 1'b1, 1'b0);
      idle(CPB + 100);
      if (r == 0) mon = 1;
    end
    mon = 0;
    idle(HOLD + 200);
    chk("rep_p1_gap", low_p1, 0);
    chk("rep_p2_gap", low_p2, 0);
    chk("rep_p1_fall", fall_p1 - last_p1, HOLD + 1);
    chk("rep_p2_fall", fall_p2 - last_p2, HOLD + 1);
    chk("rep_order", {31'd0, fall_p2 < fall_p1}, 32'd1);

    // start commands and an ignored byte
    nstart = 0;
    nrise = 0;
    send_byte(8'h20, 1'b1, 1'b0);
    idle(CPB);
    send_byte(8'h0D, 1'b1, 1'b0);
    idle(40);
    chk("start_cnt", nstart, 2);
    chk("start_rise", nrise, 2);
    nv0 = nvalid;
    nf0 = nferr;
    send_byte(8'h41, 1'b1, 1'b0);
    idle(40);
    chk("x41_rx", nvalid, nv0 + 1);
    chk("x41_outs", outs(), 32'd0);
    chk("x41_ferr", nferr, nf0);

    // stop bit low, line held low
    nv0 = nvalid;
    nf0 = nferr;
    send_byte(8'h77, 1'b0, 1'b0);
    idle(3 * CPB);
    chk("fe_pulse", nferr, nf0 + 1);
    chk("fe_no_byte", nvalid, nv0);
    chk("fe_p1", {31'd0, p1_up}, 32'd0);
    uart_rx = 1'b1;
    idle(40);
    chk("fe_quiet", nvalid, nv0);
    chk("fe_single", nferr, nf0 + 1);
    send_byte(8'h73, 1'b1, 1'b0);
    idle(40);
    chk("fe_recover", {31'd0, p1_down}, 32'd1);

    // short glitch on idle line
    nv0 = nvalid;
    nf0 = nferr;
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(300);
    chk("gl_byte", nvalid, nv0);
    chk("gl_ferr", nferr, nf0);

`ifdef UART_PARITY_EN
    nv0 = nvalid;
    nf0 = nferr;
    send_byte(8'h77, 1'b1, 1'b1);
    idle(60);
    chk("par_ferr", nferr, nf0 + 1);
    chk("par_byte", nvalid, nv0);
    chk("par_p1", {31'd0, p1_up}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
